// File: rtl/demux1to4_buf_pkg.sv
// Shared types and constants for the 1-to-4 buffered demultiplexer.
package demux1to4_buf_pkg;

  // Buffer depth in entries.
  localparam int DEPTH = 2;

  // Occupancy state; the encoding equals the number of buffered entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Destination tag carried alongside each buffered word.
  typedef logic [1:0] tag_t;

endpackage

// File: rtl/demux1to4_buf_decoder2to4.sv
// 2-to-4 one-hot decoder with enable; drives the per-destination valids.
module decoder2to4
  import demux1to4_buf_pkg::*;
(
  input  tag_t       sel,
  input  logic       en,
  output logic [3:0] onehot
);

  // One-hot of sel when enabled, all zero otherwise.
  always_comb begin
    onehot = 4'b0000;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/demux1to4_buf.sv
// Two-entry FIFO that routes each word to one of four destinations.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no entries; o_valid all zero, o_data zero
// HALF  | one entry in slot 0 (head)
// FULL  | two entries; slot 0 is head, slot 1 is next, o_ready low
module demux1to4_buf
  import demux1to4_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [1:0]            control_signal,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [3:0]            o_valid,
  input  logic [3:0]            i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_count
);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] data0_q;
  logic [DATA_WIDTH-1:0] data1_q;
  tag_t                  tag0_q;
  tag_t                  tag1_q;
  logic                  not_empty;
  logic                  push;
  logic                  pop;

  assign not_empty = (state_q != EMPTY);
  // o_ready depends only on state_q, so push has no path from i_ready.
  assign push      = i_valid && o_ready;
  // Only the ready bit of the head's own destination can pop it.
  assign pop       = |(o_valid & i_ready);

  decoder2to4 u_decoder (
    .sel    (tag0_q),
    .en     (not_empty),
    .onehot (o_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic from push/pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = HALF;
      HALF: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = HALF;
      default: state_d = EMPTY;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    o_ready = 1'b1;
    o_count = 2'd0;
    o_data  = '0;
    unique case (state_q)
      EMPTY: begin
        o_ready = 1'b1;
        o_count = 2'd0;
      end
      HALF: begin
        o_ready = 1'b1;
        o_count = 2'd1;
        o_data  = data0_q;
      end
      FULL: begin
        o_ready = 1'b0;
        o_count = 2'd2;
        o_data  = data0_q;
      end
      default: begin
        o_ready = 1'b1;
        o_count = 2'd0;
      end
    endcase
  end

  // Entry storage: slot 0 is always the head; slot 1 shifts down on pop.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      data0_q <= '0;
      data1_q <= '0;
      tag0_q  <= '0;
      tag1_q  <= '0;
    end else if (pop) begin
      if (state_q == FULL) begin
        data0_q <= data1_q;
        tag0_q  <= tag1_q;
      end else if (push) begin
        // Simultaneous push and pop in HALF: new word becomes head.
        data0_q <= i_data;
        tag0_q  <= control_signal;
      end
    end else if (push) begin
      if (state_q == EMPTY) begin
        data0_q <= i_data;
        tag0_q  <= control_signal;
      end else begin
        data1_q <= i_data;
        tag1_q  <= control_signal;
      end
    end
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Testbench for demux1to4_buf: queue model checked every cycle plus
// directed literal expectations.
module tb_demux1to4_buf;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic [1:0]    control_signal = '0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic [3:0]    o_valid;
  logic [3:0]    i_ready = '0;
  logic [DW-1:0] o_data;
  logic [1:0]    o_count;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            dest;
  } entry_t;

  entry_t q[$];

  demux1to4_buf #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .arstn          (arstn),
    .control_signal (control_signal),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_count        (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a queue of at most two entries, updated from the inputs seen at the edge.
  always @(posedge clk) begin
    if (arstn) begin
      bit do_pop;
      bit do_push;
      entry_t e;
      do_pop  = (q.size() > 0) && i_ready[q[0].dest];
      do_push = i_valid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.data = i_data;
        e.dest = int'(control_signal);
        q.push_back(e);
      end
    end
  end

  always @(negedge arstn) q.delete();

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [3:0]    ev;
    logic [DW-1:0] ed;
    ev = 4'b0000;
    ed = '0;
    if (q.size() > 0) begin
      ev[q[0].dest] = 1'b1;
      ed = q[0].data;
    end
    chk("model_o_count", DW'(o_count), DW'(q.size()));
    chk("model_o_ready", DW'(o_ready), DW'(q.size() < 2));
    chk("model_o_valid", DW'(o_valid), DW'(ev));
    chk("model_o_data", o_data, ed);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_v;

    // Reset
    #3;
    chk("rst_o_valid", DW'(o_valid), DW'(4'b0000));
    chk("rst_o_ready", DW'(o_ready), DW'(1'b1));
    chk("rst_o_count", DW'(o_count), DW'(2'd0));
    chk("rst_o_data", o_data, '0);
    step();
    arstn = 1'b1;
    step();

    // Single word to destination 2, popped the following cycle.
    i_ready = 4'b0100; i_valid = 1'b1; control_signal = 2'd2; i_data = 64'hA5;
    step();
    i_valid = 1'b0;
    chk("a5_o_valid", DW'(o_valid), DW'(4'b0100));
    chk("a5_o_data", o_data, 64'hA5);
    chk("a5_o_count", DW'(o_count), DW'(2'd1));
    step();
    chk("a5_popped_count", DW'(o_count), DW'(2'd0));
    chk("a5_popped_valid", DW'(o_valid), DW'(4'b0000));

    // Fill with i_ready low; third word must be refused.
    i_ready = 4'b0000;
    i_valid = 1'b1; control_signal = 2'd0; i_data = 64'h1;
    step();
    control_signal = 2'd3; i_data = 64'h2;
    step();
    chk("full_o_count", DW'(o_count), DW'(2'd2));
    chk("full_o_ready", DW'(o_ready), DW'(1'b0));
    control_signal = 2'd1; i_data = 64'h3;
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("full_hold_valid", DW'(o_valid), DW'(4'b0001));
      chk("full_hold_data", o_data, 64'h1);
      chk("full_hold_count", DW'(o_count), DW'(2'd2));
      step();
    end
    i_ready = 4'b0001;
    step();
    chk("second_head_valid", DW'(o_valid), DW'(4'b1000));
    chk("second_head_data", o_data, 64'h2);
    i_ready = 4'b1000;
    step();
    chk("drained_count", DW'(o_count), DW'(2'd0));

    // Head on destination 1 ignores the ready bits of other destinations.
    i_ready = 4'b1101;
    i_valid = 1'b1; control_signal = 2'd1; i_data = 64'h55;
    step();
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ignore_valid", DW'(o_valid), DW'(4'b0010));
      chk("ignore_data", o_data, 64'h55);
      step();
    end
    i_ready = 4'b0010;
    step();
    chk("ignore_drained", DW'(o_count), DW'(2'd0));

    // Streaming eight words, one per cycle, cycling through destinations.
    i_ready = 4'b1111;
    i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      control_signal = 2'(k % 4);
      i_data = 64'h10 + 64'(k);
      step();
      exp_v = 4'b0001 << (k % 4);
      chk("stream_valid", DW'(o_valid), DW'(exp_v));
      chk("stream_data", o_data, 64'h10 + 64'(k));
      chk("stream_count", DW'(o_count), DW'(2'd1));
    end
    i_valid = 1'b0;
    step();
    chk("stream_end_count", DW'(o_count), DW'(2'd0));

    // Asynchronous reset while FULL.
    i_ready = 4'b0000;
    i_valid = 1'b1; control_signal = 2'd0; i_data = 64'hB1;
    step();
    control_signal = 2'd1; i_data = 64'hB2;
    step();
    chk("prereset_count", DW'(o_count), DW'(2'd2));
    i_data = 64'hEE;
    #2;
    arstn = 1'b0;
    #1;
    chk("async_o_valid", DW'(o_valid), DW'(4'b0000));
    chk("async_o_count", DW'(o_count), DW'(2'd0));
    chk("async_o_ready", DW'(o_ready), DW'(1'b1));
    chk("async_o_data", o_data, '0);
    step();
    chk("inreset_no_push", DW'(o_count), DW'(2'd0));
    arstn = 1'b1;
    i_ready = 4'b0100; control_signal = 2'd2; i_data = 64'hC3;
    step();
    i_valid = 1'b0;
    chk("post_reset_valid", DW'(o_valid), DW'(4'b0100));
    chk("post_reset_data", o_data, 64'hC3);
    step();
    chk("post_reset_drain", DW'(o_count), DW'(2'd0));
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
